// File: rtl/pe_group_scheduler_pkg.sv
// Shared types and default layer dimensions for the PE group scheduler.
package pe_sched_pkg;

    localparam int PE_COUNT_DEF    = 3;
    localparam int FILT_GROUPS_DEF = 4;
    localparam int IF_GROUPS_DEF   = 2;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        LOAD,
        DISPATCH,
        WAIT,
        ADVANCE,
        DONE
    } sched_state_t;

endpackage

// File: rtl/pe_group_scheduler_if.sv
// Handshake and control bundle between the scheduler (master) and the
// layer controller / PE array datapath (slave).
interface pe_group_scheduler_if #(
    parameter int PE_COUNT = 3,
    parameter int FG_W     = 3,
    parameter int IG_W     = 2
);
    logic                start;
    logic                if_ack;
    logic [PE_COUNT-1:0] pe_done;
    logic                rst_dp;
    logic                ifwen;
    logic                sel_addr;
    logic [PE_COUNT-1:0] start_pe;
    logic                mod;
    logic [FG_W-1:0]     filt_grp;
    logic [IG_W-1:0]     if_grp;
    logic                busy;
    logic                done_all;

    modport master (
        input  start, if_ack, pe_done,
        output rst_dp, ifwen, sel_addr, start_pe, mod, filt_grp, if_grp, busy, done_all
    );

    modport slave (
        output start, if_ack, pe_done,
        input  rst_dp, ifwen, sel_addr, start_pe, mod, filt_grp, if_grp, busy, done_all
    );
endinterface

// File: rtl/pe_group_scheduler_onehot_ring.sv
// Rotating one-hot pointer; wrap flags the step that leaves the top bit.
module onehot_ring #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] FIRST = WIDTH'(1);

    // NOTE: clocked processes use <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= FIRST;
        end else if (clr) begin
            q <= FIRST;
        end else if (en) begin
            q <= (q << 1) | (q >> (WIDTH - 1));
        end
    end

    assign wrap = en && q[WIDTH-1];
endmodule

// File: rtl/pe_group_scheduler.sv
// Walks the PE array through every (ifmap group, filter group) pair of a layer.
// Optional SCHED_PERF_CNT_EN adds a saturating LOAD/WAIT stall counter port.
module pe_group_scheduler
    import pe_sched_pkg::*;
#(
    parameter int PE_COUNT    = PE_COUNT_DEF,
    parameter int FILT_GROUPS = FILT_GROUPS_DEF,
    parameter int IF_GROUPS   = IF_GROUPS_DEF,
    parameter int FG_W        = $clog2(FILT_GROUPS) + 1,
    parameter int IG_W        = $clog2(IF_GROUPS) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    pe_group_scheduler_if.master  bus
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);
    localparam logic [FG_W-1:0] FG_LAST = FG_W'(FILT_GROUPS - 1);
    localparam logic [IG_W-1:0] IG_LAST = IG_W'(IF_GROUPS - 1);

    sched_state_t        state, state_nx;
    logic [FG_W-1:0]     filt_grp_q;
    logic [IG_W-1:0]     if_grp_q;
    logic [PE_COUNT-1:0] done_mask;
    logic [PE_COUNT-1:0] ptr;
    logic                ptr_wrap;
    logic                mask_clr;
    logic                mask_full;
    logic                fg_more;

    onehot_ring #(.WIDTH(PE_COUNT)) u_ring (
        .clk  (clk),
        .rst  (rst),
        .en   (state == DISPATCH),
        .clr  (state == INIT),
        .q    (ptr),
        .wrap (ptr_wrap)
    );

    assign fg_more = (filt_grp_q < FG_LAST);

    // Mask clears on every entry into DISPATCH; decoded from state and inputs
    // rather than state_nx to keep the WAIT exit free of a combinational loop.
    assign mask_clr  = ((state == LOAD) && bus.if_ack) || ((state == ADVANCE) && fg_more);
    assign mask_full = &(done_mask | bus.pe_done);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (bus.start) state_nx = INIT;
            INIT:     state_nx = LOAD;
            LOAD:     if (bus.if_ack) state_nx = DISPATCH;
            DISPATCH: if (ptr_wrap) state_nx = WAIT;
            WAIT:     if (mask_full) state_nx = ADVANCE;
            ADVANCE: begin
                if (fg_more)                  state_nx = DISPATCH;
                else if (if_grp_q < IG_LAST)  state_nx = LOAD;
                else                          state_nx = DONE;
            end
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        bus.rst_dp   = 1'b0;
        bus.ifwen    = 1'b0;
        bus.sel_addr = 1'b0;
        bus.start_pe = '0;
        bus.busy     = 1'b1;
        bus.done_all = 1'b0;
        unique case (state)
            IDLE:     bus.busy = 1'b0;
            INIT:     bus.rst_dp = 1'b1;
            LOAD:     bus.ifwen = 1'b1;
            DISPATCH: begin
                bus.sel_addr = 1'b1;
                bus.start_pe = ptr;
            end
            WAIT:     bus.sel_addr = 1'b1;
            DONE:     bus.done_all = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_grp_q <= '0;
            if_grp_q   <= '0;
        end else if (state == INIT) begin
            filt_grp_q <= '0;
            if_grp_q   <= '0;
        end else if (state == ADVANCE) begin
            if (fg_more) begin
                filt_grp_q <= filt_grp_q + FG_W'(1);
            end else begin
                filt_grp_q <= '0;
                if (if_grp_q < IG_LAST) if_grp_q <= if_grp_q + IG_W'(1);
            end
        end
    end

    // A completion landing on the clear cycle is kept: set wins over clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_mask <= '0;
        end else begin
            done_mask <= (mask_clr ? '0 : done_mask) | bus.pe_done;
        end
    end

    // Gated by busy so the whole output set is quiet while idle or in reset.
    assign bus.mod      = (state != IDLE) && (filt_grp_q == '0);
    assign bus.filt_grp = filt_grp_q;
    assign bus.if_grp   = if_grp_q;

`ifdef SCHED_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (state == INIT) begin
            stall_cycles <= '0;
        end else if (((state == LOAD) || (state == WAIT)) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pe_group_scheduler.sv
// Directed bench: default-size scheduler plus a 1x1-group instance for latency and stall counting.
module tb_pe_group_scheduler;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    pe_group_scheduler_if #(.PE_COUNT(3), .FG_W(3), .IG_W(2)) bus_a ();
    pe_group_scheduler_if #(.PE_COUNT(3), .FG_W(1), .IG_W(1)) bus_b ();

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] stall_a, stall_b;
`endif

    pe_group_scheduler dut_a (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_a)
`ifdef SCHED_PERF_CNT_EN
        , .stall_cycles (stall_a)
`endif
    );

    pe_group_scheduler #(.FILT_GROUPS(1), .IF_GROUPS(1)) dut_b (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_b)
`ifdef SCHED_PERF_CNT_EN
        , .stall_cycles (stall_b)
`endif
    );

    // Environment models: if_ack after ack_dly cycles of ifwen, pe_done pe_dly cycles after start_pe.
    int         a_ack_dly = 2, a_pe_dly = 5, a_ld_cnt = 0;
    int         b_ack_dly = 0, b_pe_dly = 1, b_ld_cnt = 0;
    int         a_tmr[3] = '{-1, -1, -1};
    int         b_tmr[3] = '{-1, -1, -1};
    logic       a_auto = 1'b1;
    logic       a_ack = 1'b0, b_ack = 1'b0;
    logic [2:0] a_auto_done = '0, b_auto_done = '0, a_man_done = '0;

    assign bus_a.if_ack  = a_ack;
    assign bus_a.pe_done = a_auto ? a_auto_done : a_man_done;
    assign bus_b.if_ack  = b_ack;
    assign bus_b.pe_done = b_auto_done;

    always @(posedge clk) begin
        #1;
        a_ack    = bus_a.ifwen && (a_ld_cnt == a_ack_dly);
        a_ld_cnt = bus_a.ifwen ? a_ld_cnt + 1 : 0;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) a_tmr[i] = -1;
            else if (bus_a.start_pe[i]) a_tmr[i] = a_pe_dly;
            a_auto_done[i] = (a_tmr[i] == 0);
            if (a_tmr[i] >= 0) a_tmr[i]--;
        end
    end

    always @(posedge clk) begin
        #1;
        b_ack    = bus_b.ifwen && (b_ld_cnt == b_ack_dly);
        b_ld_cnt = bus_b.ifwen ? b_ld_cnt + 1 : 0;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) b_tmr[i] = -1;
            else if (bus_b.start_pe[i]) b_tmr[i] = b_pe_dly;
            b_auto_done[i] = (b_tmr[i] == 0);
            if (b_tmr[i] >= 0) b_tmr[i]--;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs_a();
        return 32'({bus_a.rst_dp, bus_a.ifwen, bus_a.sel_addr, bus_a.start_pe, bus_a.mod,
                    bus_a.filt_grp, bus_a.if_grp, bus_a.busy, bus_a.done_all});
    endfunction

    function automatic logic [31:0] outs_b();
        return 32'({bus_b.rst_dp, bus_b.ifwen, bus_b.sel_addr, bus_b.start_pe, bus_b.mod,
                    bus_b.filt_grp, bus_b.if_grp, bus_b.busy, bus_b.done_all});
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one default-size layer on dut_a from a negedge; returns at the done_all negedge.
    task automatic run_layer(input string tag, input bit hold);
        int   n_ifwen = 0, n_disp = 0, n_rstdp = 0, pass;
        logic prev_ifwen = 1'b0;
        bit   seen = 1'b0;
        bus_a.start = 1'b1;
        for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
            @(negedge clk);
            if (!hold) bus_a.start = 1'b0;
            if (bus_a.rst_dp) n_rstdp++;
            if (bus_a.ifwen && !prev_ifwen) begin
                n_ifwen++;
                check({tag, "_load_sel"}, 32'(bus_a.sel_addr), 32'd0);
            end
            prev_ifwen = bus_a.ifwen;
            if (bus_a.start_pe != '0) begin
                pass = n_disp / 3;
                check({tag, "_start_pe"}, 32'(bus_a.start_pe), 32'(1) << (n_disp % 3));
                check({tag, "_mod"},      32'(bus_a.mod),      32'((pass % 4) == 0));
                check({tag, "_filt_grp"}, 32'(bus_a.filt_grp), 32'(pass % 4));
                check({tag, "_if_grp"},   32'(bus_a.if_grp),   32'(pass / 4));
                check({tag, "_disp_sel"}, 32'(bus_a.sel_addr), 32'd1);
                n_disp++;
            end
            if (bus_a.done_all) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_ifwen_cnt"}, 32'(n_ifwen), 32'd2);
        check({tag, "_disp_cnt"},  32'(n_disp), 32'd24);
        check({tag, "_init_cnt"},  32'(n_rstdp), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int        n;
        bit        seen;
        bit        found;
        logic [2:0] ooo_seq [6];

        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs_a", outs_a(), 32'd0);
        check("reset_outs_b", outs_b(), 32'd0);
`ifdef SCHED_PERF_CNT_EN
        check("reset_stall", stall_b, 32'd0);
`endif
        rst_n = 1'b1;

        // Latency: 1x1 groups, zero-wait ack, 1-cycle PE done.
        @(negedge clk);
        bus_b.start = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            bus_b.start = 1'b0;
            if (bus_b.done_all) seen = 1'b1;
        end
        check("lat_cycles", 32'(n), 32'd8);
`ifdef SCHED_PERF_CNT_EN
        check("lat_stall", stall_b, 32'd2);

        // Stall counter: 11 LOAD cycles (ack after 10) plus 4 WAIT cycles.
        b_ack_dly = 10;
        b_pe_dly  = 4;
        @(negedge clk);
        bus_b.start = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            @(negedge clk);
            bus_b.start = 1'b0;
            if (bus_b.ifwen) n++;
            if (bus_b.done_all) seen = 1'b1;
        end
        check("perf_done", 32'(seen), 32'd1);
        check("perf_load_cycles", 32'(n), 32'd11);
        check("perf_stall", stall_b, 32'd15);
        repeat (4) @(negedge clk);
        check("perf_stall_hold", stall_b, 32'd15);
`endif

        // Full default layer.
        @(negedge clk);
        run_layer("layer", 1'b0);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus_a.done_all) n++;
        end
        check("layer_extra_done", 32'(n), 32'd0);
        check("layer_idle_busy", 32'(bus_a.busy), 32'd0);

        // Out-of-order completions: PE2, PE0, PE1 with gaps.
        a_auto    = 1'b0;
        a_ack_dly = 0;
        @(negedge clk);
        bus_a.start = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 50 && !found; cyc++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
            if (bus_a.start_pe == 3'b100) found = 1'b1;
        end
        check("ooo_dispatch", 32'(found), 32'd1);
        ooo_seq = '{3'b100, 3'b000, 3'b001, 3'b000, 3'b000, 3'b010};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("ooo_wait_pe", 32'(bus_a.start_pe), 32'd0);
            check("ooo_wait_fg", 32'(bus_a.filt_grp), 32'd0);
            a_man_done = ooo_seq[k];
        end
        @(negedge clk);
        a_man_done = 3'b000;
        check("ooo_adv_pe", 32'(bus_a.start_pe), 32'd0);
        check("ooo_adv_fg", 32'(bus_a.filt_grp), 32'd0);
        @(negedge clk);
        check("ooo_next_pe", 32'(bus_a.start_pe), 32'b001);
        check("ooo_next_fg", 32'(bus_a.filt_grp), 32'd1);
        a_auto = 1'b1;
        apply_reset();

        // pe_done in the same cycle as its start_pe.
        a_pe_dly = 0;
        run_layer("same_cycle", 1'b0);

        // Async reset during WAIT of filter group 2, then a clean layer.
        a_ack_dly = 2;
        a_pe_dly  = 5;
        @(negedge clk);
        bus_a.start = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 500 && !found; cyc++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
            if (bus_a.start_pe == 3'b100 && bus_a.filt_grp == 3'd2) found = 1'b1;
        end
        check("abort_find_fg2", 32'(found), 32'd1);
        repeat (2) @(negedge clk);
        check("abort_pre_wait", 32'({bus_a.busy, bus_a.sel_addr, bus_a.start_pe}), 32'b11000);
        #2 rst_n = 1'b0;
        #1 check("abort_async_outs", outs_a(), 32'd0);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_a.done_all) n++;
        end
        check("abort_no_done", 32'(n), 32'd0);
        rst_n = 1'b1;
        run_layer("post_abort", 1'b0);

        // start held high: no restart mid-layer, new INIT two cycles after done_all.
        a_ack_dly = 0;
        a_pe_dly  = 1;
        repeat (3) @(negedge clk);
        run_layer("hold", 1'b1);
        @(negedge clk);
        check("hold_idle_busy", 32'(bus_a.busy), 32'd0);
        @(negedge clk);
        check("hold_restart", 32'({bus_a.busy, bus_a.rst_dp}), 32'b11);
        bus_a.start = 1'b0;
        apply_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pe_group_scheduler.md
Name: pe_group_scheduler

Overview:
- Sequences a PE_COUNT-wide processing-element array through every (ifmap group, filter group) pair of a convolution layer.
- Per pair: loads the ifmap buffer through a handshake, dispatches one start pulse to each PE in rotating one-hot order, then waits until every PE reports done.
- Sits between the layer-level start/done interface and the PE array datapath. Drives the datapath reset, the address select, the mode bit and the group counters.

Parameters:
- PE_COUNT, 3, number of PEs; one-hot dispatch width.
- FILT_GROUPS, 4, filter groups per ifmap group; must be >= 1.
- IF_GROUPS, 2, ifmap groups per layer; must be >= 1.
- FG_W, $clog2(FILT_GROUPS)+1, width of the filter-group index.
- IG_W, $clog2(IF_GROUPS)+1, width of the ifmap-group index.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, layer start; sampled only in IDLE.
- if_ack, input, 1, ifmap buffer load complete.
- pe_done, input, PE_COUNT, per-PE completion pulses.
- rst_dp, output, 1, datapath clear.
- ifwen, output, 1, ifmap buffer write enable.
- sel_addr, output, 1, 0 = load addressing, 1 = compute addressing.
- start_pe, output, PE_COUNT, one-hot PE start pulse.
- mod, output, 1, 1 when filt_grp == 0 (PEs overwrite partial sums); 0 otherwise (PEs accumulate).
- filt_grp, output, FG_W, current filter-group index.
- if_grp, output, IG_W, current ifmap-group index.
- busy, output, 1, high in every state except IDLE.
- done_all, output, 1, one-cycle layer-complete pulse.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-low.
- Reset (rst = 0) forces: state IDLE; all outputs 0; one-hot pointer = bit 0; done mask cleared. Reset mid-layer aborts immediately and produces no done_all.
- IDLE:
  - start = 1 -> INIT.
  - start while busy is ignored.
- INIT: exactly one cycle.
  - rst_dp = 1.
  - filt_grp = 0, if_grp = 0.
  - -> LOAD.
- LOAD:
  - ifwen = 1, sel_addr = 0, held until if_ack = 1.
  - The cycle if_ack is seen: ifwen drops next cycle and state -> DISPATCH.
  - if_ack already high on LOAD entry -> one-cycle LOAD.
- DISPATCH: lasts PE_COUNT cycles.
  - sel_addr = 1.
  - start_pe = current one-hot pointer; pointer rotates left by one each cycle.
  - Exactly one start_pe bit is high per cycle.
  - After the bit for PE_COUNT-1, the pointer wraps to bit 0 and state -> WAIT.
- Done mask (sticky, PE_COUNT bits):
  - Cleared on entry to DISPATCH.
  - Sets bit i on pe_done[i], including during DISPATCH.
  - A pe_done arriving the same cycle as the clear is kept (set wins).
- WAIT:
  - Stays until the mask is all ones.
  - Then -> ADVANCE.
- ADVANCE: one cycle.
  - If filt_grp < FILT_GROUPS-1: filt_grp += 1, -> DISPATCH (no reload).
  - Else filt_grp = 0, and:
    - if if_grp < IF_GROUPS-1: if_grp += 1, -> LOAD;
    - else -> DONE.
- DONE: done_all = 1 for one cycle; -> IDLE.
- mod is combinational from filt_grp.
- Latency: PE_COUNT = 3, FILT_GROUPS = 1, IF_GROUPS = 1, zero-wait if_ack, PE done in 1 cycle after start -> start to done_all = 8 cycles.

Optional Feature:
- Macro: SCHED_PERF_CNT_EN.
- Defined:
  - Adds output port stall_cycles (32-bit).
  - stall_cycles counts cycles spent in LOAD or WAIT, saturating at all ones.
  - It clears on INIT and holds its value in IDLE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package pe_sched_pkg holds:
  - the state enum: IDLE, INIT, LOAD, DISPATCH, WAIT, ADVANCE, DONE;
  - the localparam default counts.
- Sub-module onehot_ring (parameter WIDTH) provides the rotating one-hot pointer:
  - inputs en and clr;
  - outputs q and wrap;
  - reset value is bit 0.
- The FSM, counters and done mask stay in the top module.

Test Plan:
- Defaults (PE_COUNT 3, FILT_GROUPS 4, IF_GROUPS 2), if_ack 2 cycles after ifwen, pe_done 5 cycles after each start_pe -> required response:
  - ifwen asserted twice;
  - start_pe sequence 001, 010, 100 repeated 8 times;
  - mod = 1 only on passes with filt_grp = 0;
  - exactly one done_all.
- Out-of-order pe_done (PE2, then PE0, then PE1) with gaps -> WAIT exits only after the third done; the ADVANCE cycle follows.
- pe_done[0] asserted in the same cycle as start_pe = 001 -> captured; no deadlock.
- rst pulled low during WAIT of filter group 2 -> all outputs 0 asynchronously and no done_all; a later start runs a full layer from filt_grp = 0.
- start held high throughout the layer -> no restart while busy; a new layer begins the cycle after done_all returns to IDLE.
- SCHED_PERF_CNT_EN defined, if_ack delayed 10 cycles, PE done 4 cycles after start, FILT_GROUPS = 1, IF_GROUPS = 1 -> stall_cycles matches the LOAD plus WAIT cycles counted by the bench.
